// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and constants for the memory responder
package mem_resp_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int BE_W   = WORD_W / BYTE_W;

  // Wide enough for LATENCY up to 15
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word storage with byte-enabled write and registered read
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  // Contents are deliberately not reset
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Byte-enabled write and registered read share the single port
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem_q[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
    if (re) begin
      rdata <= mem_q[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - request/response memory responder with fixed latency
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              live_q;
  logic              we_q;
  logic              err_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              idle;
  logic              accept;
  logic              req_err;
  logic              go_resp;
  logic              acc_we;
  logic              acc_err;
  logic [AW-1:0]     acc_idx;
  logic [WORD_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] mem_rdata;

  assign idle        = (state_q == IDLE);
  // live_q keeps ready low until the first edge after reset release
  assign req_ready_o = idle && live_q;
  assign accept      = req_valid_i && req_ready_o;
  assign req_err     = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:2] >= 30'(DEPTH_WORDS));

  // With zero latency the memory access happens on the accept edge, so use the live inputs
  assign acc_we    = idle ? req_we_i              : we_q;
  assign acc_err   = idle ? req_err               : err_q;
  assign acc_idx   = idle ? req_addr_i[AW+1:2]    : idx_q;
  assign acc_wdata = idle ? req_wdata_i           : wdata_q;
  assign acc_be    = idle ? req_be_i              : be_q;

  assign go_resp = rst_i && ((accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == '0)));
  assign mem_we  = go_resp && acc_we && !acc_err;
  assign mem_re  = go_resp && !acc_we && !acc_err;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk   (clk_i),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (mem_rdata)
  );

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = (rsp_valid_o && !we_q && !err_q) ? mem_rdata : '0;

  // State, counter and request capture registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      live_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      if (accept) begin
        we_q    <= req_we_i;
        err_q   <= req_err;
        idx_q   <= req_addr_i[AW+1:2];
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
    end
  end

  // Next-state and latency counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
